// File: rtl/dmem_pkg.sv
// ---------------------------------------------------------------------------
// dmem_pkg
//   Shared types and constants for the data-memory line backend.
//   - dmem_state_e : backend FSM states (2-bit encoding)
//   - LINE_W       : default line width in bits (32-byte line)
//   - LINE_OFFSET_W: byte-offset bits inside a line (ignored on the address)
//   - CNT_W        : latency counter width (latency 1..255)
// ---------------------------------------------------------------------------
package dmem_pkg;

    localparam int LINE_W        = 256;
    localparam int LINE_OFFSET_W = 5;
    localparam int CNT_W         = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ACK  = 2'd2,
        ST_DONE = 2'd3
    } dmem_state_e;

    // Counter value loaded on acceptance: the BUSY phase runs until the
    // counter reaches zero, so LATENCY-1 gives ack exactly LATENCY+1
    // cycles after the request is seen.
    function automatic logic [CNT_W-1:0] latency_preload(input int latency);
        return CNT_W'(latency - 1);
    endfunction

endpackage

// File: rtl/dmem_line_array.sv
// ---------------------------------------------------------------------------
// dmem_line_array
//   DEPTH x LINE_W line storage. Contents are never reset.
//   Ports:
//     clk_i    in   clock
//     we_i     in   write enable (synchronous write)
//     waddr_i  in   write line index
//     wdata_i  in   write line data
//     raddr_i  in   read line index
//     rdata_o  out  read line data (combinational)
//   The storage array is named mem so it can be preloaded hierarchically.
// ---------------------------------------------------------------------------
module dmem_line_array #(
    parameter int LINE_W = 256,
    parameter int DEPTH  = 512,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  waddr_i,
    input  logic [LINE_W-1:0] wdata_i,
    input  logic [IDX_W-1:0]  raddr_i,
    output logic [LINE_W-1:0] rdata_o
);

    logic [LINE_W-1:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/dmem_line_backend.sv
// ---------------------------------------------------------------------------
// dmem_line_backend
//   Off-chip data memory model behind the data cache's memory port.
//   One 256-bit line read or write per request, fixed LATENCY, one-cycle
//   ack pulse, read data held until the next read ack.
//   Ports:
//     clk_i        in   clock
//     rst_i        in   asynchronous reset, active-low
//     addr_i       in   byte address (offset bits and bits above index ignored)
//     data_i       in   write line
//     enable_i     in   request valid (level)
//     write_i      in   1 = write, 0 = read; sampled with enable_i
//     ack_o        out  one-cycle completion pulse
//     data_o       out  read line, valid from the ack cycle until next read ack
//     dbg_state_o  out  current FSM state
//
//   Handshake: enable_i is a level request. It is sampled only in IDLE;
//   in that cycle addr_i/write_i/data_i are latched and the request is
//   committed. Nothing aborts a committed request except reset. The
//   requester may hold enable_i high until it sees ack_o and for one
//   cycle after (DONE ignores it); a level still high when IDLE is
//   reached again starts a new request (used for writeback -> refill).
// ---------------------------------------------------------------------------
module dmem_line_backend
    import dmem_pkg::*;
#(
    parameter int LINE_W  = dmem_pkg::LINE_W,
    parameter int ADDR_W  = 32,
    parameter int DEPTH   = 512,
    parameter int LATENCY = 10
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [LINE_W-1:0] data_i,
    input  logic              enable_i,
    input  logic              write_i,
    output logic              ack_o,
    output logic [LINE_W-1:0] data_o,
    output dmem_state_e       dbg_state_o
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_PRELOAD = latency_preload(LATENCY);

    dmem_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              wr_q, wr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic [LINE_W-1:0] data_q, data_d;

    logic [LINE_W-1:0] arr_rdata;
    logic              arr_we;

    // Offset bits and the bits above the index simply wrap.
    logic unused_addr;
    assign unused_addr = ^{addr_i[ADDR_W-1:LINE_OFFSET_W+IDX_W],
                           addr_i[LINE_OFFSET_W-1:0]};

    dmem_line_array #(
        .LINE_W (LINE_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk_i   (clk_i),
        .we_i    (arr_we),
        .waddr_i (idx_q),
        .wdata_i (wdata_q),
        .raddr_i (idx_q),
        .rdata_o (arr_rdata)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
        data_d  = data_q;
        case (state_q)
            ST_IDLE: begin
                if (enable_i) begin
                    idx_d   = addr_i[LINE_OFFSET_W +: IDX_W];
                    wr_d    = write_i;
                    wdata_d = data_i;
                    cnt_d   = CNT_PRELOAD;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (cnt_q == '0) begin
                    state_d = ST_ACK;
                    // Read data lands in data_o on the edge entering ACK.
                    if (!wr_q) begin
                        data_d = arr_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_ACK: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                // Recovery cycle: the cache still holds enable after a read ack.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Write commits on the edge leaving ACK, so a reset during BUSY never
    // touches the array.
    assign arr_we      = (state_q == ST_ACK) && wr_q;
    assign ack_o       = (state_q == ST_ACK);
    assign data_o      = data_q;
    assign dbg_state_o = state_q;

endmodule
